ifu_fq: RTL and testbench

IFU_FQ -- requirements
Module: ifu_fq

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fq_fifo.sv | 60 ++++++
 rtl/ifu_fq.sv | 100 ++++++++++
 tb/tb_ifu_fq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared defaults and FSM encoding for the instruction fetch unit.
// Module-level parameters are seeded from these so every IFU block agrees on widths.
package ifu_pkg;

  localparam int unsigned IFU_ADDR_WIDTH = 32;
  localparam int unsigned IFU_INST_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
  localparam int unsigned IFU_FQ_DEPTH   = 4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fq_state_e;

endpackage

// File: rtl/ifu_fq_fifo.sv
// Fetch-queue storage: power-of-two FIFO with flush and a head read from registered storage.
// A push is only visible on out_valid one cycle later, so there is no push-to-valid path.
module ifu_fq_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned WIDTH = IFU_ADDR_WIDTH + IFU_INST_WIDTH + 1,
  parameter int unsigned DEPTH = IFU_FQ_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // Flush has priority: a same-cycle push or pop is simply dropped.
  always_comb begin
    out_valid = (count_q != '0);
    out_data  = mem_q[rd_ptr_q];
    count     = count_q;
    do_pop    = out_valid && pop_ready && !flush;
    do_push   = push_valid && !flush && ((count_q != (PW+1)'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fq.sv
// Instruction fetch front end: one outstanding icache request, sequential pc, redirect/flush,
// and a fetch queue feeding the decoder.
module ifu_fq
  import ifu_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = IFU_ADDR_WIDTH,
  parameter int unsigned            INST_WIDTH = IFU_INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC),
  parameter int unsigned            FQ_DEPTH   = IFU_FQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [INST_WIDTH-1:0] rsp_data,
  input  logic                  rsp_err,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  idu_valid,
  input  logic                  idu_ready,
  output logic [ADDR_WIDTH-1:0] idu_pc,
  output logic [INST_WIDTH-1:0] idu_instr,
  output logic                  idu_err
);

  localparam int unsigned ENT_W = ADDR_WIDTH + INST_WIDTH + 1;
  localparam int unsigned CW    = $clog2(FQ_DEPTH) + 1;

  fq_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  req_fire;
  logic                  fq_push;
  logic [CW-1:0]         fq_count;
  logic [ENT_W-1:0]      fq_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // A redirect always retargets the pc; if a request is in flight its response must be drained.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    case (state_q)
      ST_FETCH: if (req_fire) state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        if (rsp_valid)           state_d = ST_FETCH;
        else if (redirect_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (rsp_valid) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
    if (req_fire) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + ADDR_WIDTH'(4);
    end
    if (redirect_valid) pc_d = redirect_pc;
  end

  always_comb begin
    req_valid = (state_q == ST_FETCH) && (fq_count < CW'(FQ_DEPTH));
    req_addr  = pc_q;
    req_fire  = req_valid && req_ready;
    fq_push   = (state_q == ST_WAIT) && rsp_valid && !redirect_valid;
  end

  ifu_fq_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push_valid (fq_push),
    .push_data  ({req_pc_q, rsp_data, rsp_err}),
    .pop_ready  (idu_ready),
    .out_valid  (idu_valid),
    .out_data   (fq_head),
    .count      (fq_count)
  );

  assign {idu_pc, idu_instr, idu_err} = fq_head;

  // A response with nothing outstanding means the icache protocol was broken; it is dropped.
  rsp_in_fetch_a: assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid && (state_q == ST_FETCH)));

endmodule

// File: tb/tb_ifu_fq.sv
// Directed and randomized checks of ifu_fq against a queue-based fetch model and an icache stub.
module tb_ifu_fq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, rsp_err, redirect_valid;
  logic        idu_valid, idu_ready, idu_err;
  logic [31:0] req_addr, rsp_data, redirect_pc, idu_pc, idu_instr;

  always #5 clk = ~clk;

  ifu_fq #(.ADDR_WIDTH(32), .INST_WIDTH(32), .RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .idu_valid(idu_valid), .idu_ready(idu_ready),
    .idu_pc(idu_pc), .idu_instr(idu_instr), .idu_err(idu_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } ent_t;

  // Reference model: delivered-instruction queue, fetch pc, and one in-flight request
  ent_t        mq[$];
  logic [31:0] m_pc, m_req_pc;
  bit          m_out, m_keep;

  // icache stub
  int          ic_cnt;
  logic [31:0] ic_addr;
  int          lat_lo = 1, lat_hi = 1;
  logic [31:0] err_addr;
  bit          err_rand;

  int checks = 0, failures = 0, cyc = 0, fire_cnt = 0;
  logic [31:0] pop_pc[$];
  logic        pop_err[$];
  int          pop_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return (a == err_addr) || (err_rand && (a[5:2] == 4'hB));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: compare outputs, drive inputs, advance the model, move one cycle.
  task automatic cycle(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
    bit exp_rv, m_fire;
    exp_rv = !m_out && (mq.size() < DEPTH);
    check("req_valid", req_valid, exp_rv);
    if (exp_rv) check("req_addr", req_addr, m_pc);
    check("idu_valid", idu_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("idu_pc", idu_pc, mq[0].pc);
      check("idu_instr", idu_instr, mq[0].instr);
      check("idu_err", idu_err, mq[0].err);
    end

    req_ready = rdy; idu_ready = irdy; redirect_valid = redir; redirect_pc = rpc;
    rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    if (ic_cnt > 0) begin
      ic_cnt--;
      if (ic_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_word(ic_addr);
        rsp_err   = mem_err(ic_addr);
      end
    end
    if (req_valid === 1'b1 && rdy) begin
      fire_cnt++;
      ic_addr = req_addr;
      ic_cnt  = $urandom_range(lat_hi, lat_lo);
    end
    if (idu_valid === 1'b1 && irdy && !redir) begin
      pop_pc.push_back(idu_pc);
      pop_err.push_back(idu_err);
      pop_cyc.push_back(cyc);
    end

    m_fire = exp_rv && rdy;
    if (redir) begin
      mq.delete();
      m_pc = rpc;
      if (m_fire) begin
        m_out = 1'b1; m_keep = 1'b0;
      end else if (m_out && rsp_valid) begin
        m_out = 1'b0;
      end else begin
        m_keep = 1'b0;
      end
    end else begin
      if (mq.size() != 0 && irdy) void'(mq.pop_front());
      if (m_out && rsp_valid) begin
        if (m_keep) mq.push_back('{m_req_pc, rsp_data, rsp_err});
        m_out = 1'b0;
      end
      if (m_fire) begin
        m_out = 1'b1; m_keep = 1'b1; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_ready = 1'b0; idu_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_idu_valid", idu_valid, 1'b0);
    check("rst_req_valid", req_valid, 1'b1);
    check("rst_req_addr", req_addr, RST_PC);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete(); m_pc = RST_PC; m_req_pc = RST_PC; m_out = 1'b0; m_keep = 1'b0;
    ic_cnt = 0; fire_cnt = 0; cyc = 0;
    pop_pc.delete(); pop_err.delete(); pop_cyc.delete();
  endtask

  initial begin
    bit          rd, ir, rv;
    logic [31:0] rp;
    err_addr = 32'hFFFF_FFFF;
    err_rand = 1'b0;

    // Sequential fetch with 1-cycle responses: one delivery every two cycles
    do_reset();
    lat_lo = 1; lat_hi = 1;
    repeat (7) cycle(1, 1, 0, '0);
    check("seq_count", pop_pc.size(), 3);
    if (pop_pc.size() >= 3) begin
      check("seq_pc0", pop_pc[0], 32'h8000_0000);
      check("seq_pc1", pop_pc[1], 32'h8000_0004);
      check("seq_pc2", pop_pc[2], 32'h8000_0008);
      check("seq_gap1", pop_cyc[1] - pop_cyc[0], 2);
      check("seq_gap2", pop_cyc[2] - pop_cyc[1], 2);
    end

    // Decoder stalled: queue fills to depth, then one pop allows exactly one more request
    do_reset();
    repeat (12) cycle(1, 0, 0, '0);
    check("full_req_valid", req_valid, 1'b0);
    check("full_head_pc", idu_pc, RST_PC);
    fire_cnt = 0;
    cycle(1, 1, 0, '0);
    check("refill_req_valid", req_valid, 1'b1);
    repeat (6) cycle(1, 0, 0, '0);
    check("refill_fires", fire_cnt, 1);

    // Redirect while waiting; response arrives three cycles later and is dropped
    do_reset();
    lat_lo = 4; lat_hi = 4;
    cycle(1, 1, 0, '0);
    cycle(0, 1, 1, 32'h8000_0100);
    repeat (3) cycle(0, 1, 0, '0);
    check("drain_req_valid", req_valid, 1'b1);
    check("drain_req_addr", req_addr, 32'h8000_0100);
    check("drain_idu_valid", idu_valid, 1'b0);
    lat_lo = 1; lat_hi = 1;
    repeat (2) cycle(1, 0, 0, '0);
    check("drain_first_pc", idu_pc, 32'h8000_0100);
    check("drain_first_instr", idu_instr, mem_word(32'h8000_0100));

    // Redirect coinciding with a response while two entries are queued
    do_reset();
    repeat (5) cycle(1, 0, 0, '0);
    check("pre_flush_head", idu_pc, RST_PC);
    cycle(0, 0, 1, 32'h8000_0200);
    check("flush_idu_valid", idu_valid, 1'b0);
    check("flush_req_valid", req_valid, 1'b1);
    check("flush_req_addr", req_addr, 32'h8000_0200);
    repeat (4) cycle(1, 1, 0, '0);
    check("flush_pops", pop_pc.size(), 1);
    if (pop_pc.size() >= 1) check("flush_pop_pc", pop_pc[0], 32'h8000_0200);

    // Fetch pc wraps from the top of the address space
    do_reset();
    cycle(0, 1, 1, 32'hFFFF_FFFC);
    check("wrap_addr0", req_addr, 32'hFFFF_FFFC);
    cycle(1, 1, 0, '0);
    cycle(0, 1, 0, '0);
    check("wrap_req_valid", req_valid, 1'b1);
    check("wrap_addr1", req_addr, 32'h0000_0000);

    // Access fault is delivered only with its own entry
    do_reset();
    err_addr = 32'h8000_0008;
    repeat (12) cycle(1, 1, 0, '0);
    check("err_count", pop_err.size(), 5);
    for (int i = 0; i < pop_err.size(); i++) begin
      check($sformatf("err_entry%0d", i), pop_err[i], (i == 2) ? 1'b1 : 1'b0);
    end

    // Randomized traffic with variable latency, stalls, redirects and a mid-run reset
    do_reset();
    err_addr = 32'h8000_0010;
    err_rand = 1'b1;
    lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(99) < 75);
      ir = ($urandom_range(99) < 55);
      rv = ($urandom_range(99) < 4);
      rp = $urandom();
      rp[1:0] = 2'b00;
      if ($urandom_range(3) == 0) rp[31:4] = '1;
      if (i == 1500) do_reset();
      cycle(rd, ir, rv, rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
